// File: rtl/switch_debounce_led.sv
// -----------------------------------------------------------------------------
// switch_debounce_led
//
// Debounces N_CH raw mechanical switches and drives N_CH registered LEDs.
// Each channel passes through a two-flop synchroniser, then a saturating
// debounce counter. The counter accepts a new level only after it has held
// for DEBOUNCE_CYC consecutive cycles. A 0->1 change of a debounced level
// raises a one-cycle rise pulse, and that pulse flips a per-channel toggle
// latch. The LED source is selected by mode:
//   00 direct    : leds = sw_stable
//   01 toggle    : leds = toggle latches
//   10 blink     : leds = sw_stable AND blink phase (optional feature)
//   11 lamp test : leds = all ones
//
// Optional feature macro: SWITCH_DEBOUNCE_LED_BLINK_EN
//   defined   -> blink prescaler, phase register and blink mode are built
//   undefined -> no blink logic exists; mode 10 behaves as mode 00
//
// Ports
//   clk        in   1     rising-edge system clock
//   rst_n      in   1     asynchronous active-low reset
//   switches   in   N_CH  raw asynchronous switch levels
//   mode       in   2     LED source select, synchronous to clk
//   leds       out  N_CH  registered LED drive
//   sw_stable  out  N_CH  debounced switch levels
//   sw_rise    out  N_CH  one-cycle pulse when sw_stable goes 0->1
// -----------------------------------------------------------------------------
module switch_debounce_led #(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int BLINK_DIV    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] switches,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] leds,
  output logic [N_CH-1:0] sw_stable,
  output logic [N_CH-1:0] sw_rise
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_LAMP   = 2'b11
  } mode_e;

  localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  // Elaboration-time parameter range checks.
  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("N_CH must be in 1..32");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be at least 1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be at least 1");
  end

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [N_CH-1:0] stable_q, stable_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] tgl_q, tgl_d;
  logic [N_CH-1:0] leds_q, leds_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];

  // Two-flop synchroniser: nothing downstream sees the raw switches.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count while the synchronised level disagrees with the stable
  // level, accept on the DEBOUNCE_CYC-th disagreeing edge, clear on any
  // agreement. The counter saturates at CNT_LAST by construction.
  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // The rise pulse is registered next to sw_stable, so it is visible in the
  // cycle right after the accepting edge; the toggle latch follows a cycle
  // later and flips in every mode.
  assign tgl_d = tgl_q ^ rise_q;

  // NOTE: the counter array is reset along with everything else, so a reset
  // during a debounce always abandons the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      rise_q   <= '0;
      tgl_q    <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      tgl_q    <= tgl_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef SWITCH_DEBOUNCE_LED_BLINK_EN
  localparam int            PW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          phase_q;

  // Free-running prescaler; the phase flips each time it wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end
`endif

  // LED source select; only the leds register reacts to a mode change.
  always_comb begin
    leds_d = stable_q;
    case (mode_e'(mode))
      MODE_DIRECT: leds_d = stable_q;
      MODE_TOGGLE: leds_d = tgl_q;
`ifdef SWITCH_DEBOUNCE_LED_BLINK_EN
      MODE_BLINK:  leds_d = stable_q & {N_CH{phase_q}};
`else
      MODE_BLINK:  leds_d = stable_q;
`endif
      MODE_LAMP:   leds_d = '1;
      default:     leds_d = stable_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) leds_q <= '0;
    else        leds_q <= leds_d;
  end

  assign leds      = leds_q;
  assign sw_stable = stable_q;
  assign sw_rise   = rise_q;

endmodule

// File: tb/tb_switch_debounce_led.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_led
//
// Directed bench for switch_debounce_led with N_CH=4, DEBOUNCE_CYC=4,
// BLINK_DIV=8. Inputs change 1 ns after a rising edge and outputs are sampled
// at the same point, so "after edge n" means n rising edges after the input
// change. Expected values are hand-derived: sw_stable after edge 6, leds in
// direct mode after edge 7, leds in toggle mode after edge 8.
// -----------------------------------------------------------------------------
module tb_switch_debounce_led;

  localparam int N_CH = 4;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] switches;
  logic [1:0]      mode;
  logic [N_CH-1:0] leds;
  logic [N_CH-1:0] sw_stable;
  logic [N_CH-1:0] sw_rise;

  int checks   = 0;
  int failures = 0;

  switch_debounce_led #(
    .N_CH        (N_CH),
    .DEBOUNCE_CYC(4),
    .BLINK_DIV   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .switches (switches),
    .mode     (mode),
    .leds     (leds),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release 1 ns after an edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] acc_stable, acc_rise, acc_leds;
    logic [3:0] prev, exp_led;

    rst_n    = 1'b0;
    switches = '0;
    mode     = 2'b00;
    tick(2);
    check("reset_leds",   32'(leds),      32'h0);
    check("reset_stable", 32'(sw_stable), 32'h0);
    check("reset_rise",   32'(sw_rise),   32'h0);
    rst_n = 1'b1;

    // Clean press 1010 in direct mode.
    switches = 4'b1010;
    tick(5);
    check("press_stable_e5", 32'(sw_stable), 32'h0);
    tick(1);
    check("press_stable_e6", 32'(sw_stable), 32'ha);
    check("press_rise_e6",   32'(sw_rise),   32'ha);
    check("press_leds_e6",   32'(leds),      32'h0);
    tick(1);
    check("press_leds_e7",   32'(leds),      32'ha);
    check("press_rise_e7",   32'(sw_rise),   32'h0);

    // Release: falling edge gives no rise pulse.
    switches = 4'b0000;
    tick(6);
    check("release_stable", 32'(sw_stable), 32'h0);
    check("release_rise",   32'(sw_rise),   32'h0);
    tick(1);
    check("release_leds",   32'(leds),      32'h0);

    // 3-cycle glitch on channel 0 is discarded.
    acc_stable = '0; acc_rise = '0; acc_leds = '0;
    switches = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 3) switches = 4'b0000;
      acc_stable |= sw_stable;
      acc_rise   |= sw_rise;
      acc_leds   |= leds;
    end
    check("glitch3_stable", 32'(acc_stable), 32'h0);
    check("glitch3_rise",   32'(acc_rise),   32'h0);
    check("glitch3_leds",   32'(acc_leds),   32'h0);

    // 4-cycle pulse is exactly long enough to be accepted.
    switches = 4'b0001;
    tick(4);
    switches = 4'b0000;
    tick(2);
    check("pulse4_stable_up", 32'(sw_stable), 32'h1);
    check("pulse4_rise",      32'(sw_rise),   32'h1);
    tick(4);
    check("pulse4_stable_dn", 32'(sw_stable), 32'h0);

    // Toggle mode: two press/release cycles on channel 2.
    mode = 2'b01;
    pulse_reset();
    switches = 4'b0100;
    tick(7);
    check("tgl1_leds_e7", 32'(leds), 32'h0);
    tick(1);
    check("tgl1_leds_e8", 32'(leds), 32'h4);
    tick(2);
    switches = 4'b0000;
    tick(10);
    check("tgl1_hold", 32'(leds), 32'h4);

    // Mode changes alter only leds; toggle state survives.
    mode = 2'b00;
    tick(1);
    check("mode_direct", 32'(leds), 32'h0);
    mode = 2'b11;
    tick(1);
    check("mode_lamp",   32'(leds), 32'hf);
    mode = 2'b01;
    tick(1);
    check("mode_toggle", 32'(leds), 32'h4);

    switches = 4'b0100;
    tick(8);
    check("tgl2_leds", 32'(leds), 32'h0);
    tick(2);
    switches = 4'b0000;
    tick(10);
    check("tgl2_hold", 32'(leds), 32'h0);

    // Blink mode with 0011 held from reset release.
    mode     = 2'b10;
    switches = 4'b0011;
    pulse_reset();
    for (int n = 1; n <= 40; n++) begin
      tick(1);
      if (n >= 7) begin
`ifdef SWITCH_DEBOUNCE_LED_BLINK_EN
        exp_led = ((((n - 1) / 8) % 2) == 1) ? 4'b0011 : 4'b0000;
`else
        exp_led = 4'b0011;
`endif
        check($sformatf("blink_n%0d", n), 32'(leds), 32'(exp_led));
      end
    end

    // Lamp test, then reset in the middle of a debounce.
    mode = 2'b11;
    tick(1);
    check("lamp_leds", 32'(leds), 32'hf);
    switches = 4'b1100;
    tick(4);
    check("lamp_leds_mid",   32'(leds),      32'hf);
    check("lamp_stable_mid", 32'(sw_stable), 32'h3);
    rst_n = 1'b0;
    #1;
    check("async_rst_leds",   32'(leds),      32'h0);
    check("async_rst_stable", 32'(sw_stable), 32'h0);
    check("async_rst_rise",   32'(sw_rise),   32'h0);
    tick(2);
    mode  = 2'b00;
    rst_n = 1'b1;
    tick(5);
    check("post_rst_stable_e5", 32'(sw_stable), 32'h0);
    tick(1);
    check("post_rst_stable_e6", 32'(sw_stable), 32'hc);
    check("post_rst_rise_e6",   32'(sw_rise),   32'hc);
    tick(1);
    check("post_rst_leds_e7",   32'(leds),      32'hc);

    // Sweep all 16 values in direct mode, latency 7 each.
    prev = 4'b1100;
    for (int v = 0; v < 16; v++) begin
      switches = 4'(v);
      tick(6);
      check($sformatf("sweep%0d_e6", v), 32'(leds), 32'(prev));
      tick(1);
      check($sformatf("sweep%0d_e7", v), 32'(leds), 32'(v));
      tick(3);
      prev = 4'(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_debounce_led.md
SWITCH_DEBOUNCE_LED -- requirements
Module: switch_debounce_led

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter N_CH, default 4: number of switch/LED channels, legal range 1..32.
REQ-003 Parameter DEBOUNCE_CYC, default 16: consecutive cycles a synchronised level must differ from the stable level before it is accepted, minimum 1.
REQ-004 Parameter BLINK_DIV, default 8: cycles per blink half-period, minimum 1.
REQ-005 Port clk  input  1  rising-edge system clock.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port switches  input  N_CH  raw asynchronous switch levels.
REQ-008 Port mode  input  2  output mode select; synchronous to clk.
REQ-009 Port leds  output  N_CH  registered LED drive.
REQ-010 Port sw_stable  output  N_CH  debounced switch levels.
REQ-011 Port sw_rise  output  N_CH  one-cycle pulse per channel when sw_stable goes 0->1.

Function
REQ-012 Each channel SHALL pass through a two-flop synchroniser (sync1, then sync2) before any other logic.
REQ-013 Each channel SHALL have a debounce counter of width clog2(DEBOUNCE_CYC+1).
REQ-014 Debounce rule, on each edge where sync2 != sw_stable: if cnt == DEBOUNCE_CYC-1, load sw_stable from sync2 and clear cnt; otherwise increment cnt.
REQ-015 Debounce rule, on each edge where sync2 == sw_stable: clear cnt, so a glitch shorter than DEBOUNCE_CYC is discarded.
REQ-016 sw_rise[i] SHALL assert for exactly the one cycle following the edge where sw_stable[i] changes 0->1; a 1->0 change produces no pulse.
REQ-017 Toggle latch tgl[i] SHALL invert on every sw_rise[i] pulse, in every mode.
REQ-018 Blink phase SHALL come from a free-running prescaler counting 0..BLINK_DIV-1; phase inverts on wrap.
REQ-019 leds SHALL be registered, with the source selected by mode:
- 00 direct: leds = sw_stable
- 01 toggle: leds = tgl
- 10 blink: leds = sw_stable AND phase, replicated across channels
- 11 lamp test: leds = all ones
REQ-020 A mode change SHALL affect leds on the first clock edge after mode is sampled; no state other than the leds register is altered by the change.
REQ-021 Direct-mode latency: a clean switch change SHALL appear on leds exactly DEBOUNCE_CYC+3 rising edges after the input changes.
REQ-022 Channels SHALL be fully independent; simultaneous changes on all channels SHALL debounce in parallel with identical latency.
REQ-023 The counter SHALL never exceed DEBOUNCE_CYC-1; no wrap-around is possible.

Reset
REQ-024 While rst_n is low, the following SHALL all be 0, asynchronously: sync flops, counters, sw_stable, sw_rise, tgl, prescaler, phase and leds.
REQ-025 Reset asserted mid-debounce SHALL abandon the count; after release, debouncing restarts from sw_stable = 0.
REQ-026 Reset release SHALL be followed by normal operation from the first clock edge; switches already high at release produce sw_rise after DEBOUNCE_CYC+2 edges.

Configuration
REQ-027 Macro SWITCH_DEBOUNCE_LED_BLINK_EN defined: the prescaler, the phase register and blink mode 10 SHALL be compiled in.
REQ-028 Macro SWITCH_DEBOUNCE_LED_BLINK_EN undefined: no prescaler or phase logic SHALL exist, and mode 10 SHALL behave exactly as mode 00.

Verification (N_CH=4, DEBOUNCE_CYC=4, BLINK_DIV=8)
REQ-029 Scenario: reset, then switches=4'b1010 held, mode=00 -> sw_stable=1010 after edge 6, leds=1010 after edge 7, and sw_rise=1010 for one cycle.
REQ-030 Scenario: switches[0] pulsed high for 3 cycles -> sw_stable, leds and sw_rise remain 0.
REQ-031 Scenario: mode=01, switches[2] pressed and released twice with each level held 10 cycles -> leds[2] goes 0->1->0 and other channels stay 0.
REQ-032 Scenario: mode=10 with the macro defined, switches=4'b0011 stable -> leds alternate 0011/0000 every 8 cycles; the same stimulus without the macro -> constant 0011.
REQ-033 Scenario: mode=11 -> leds=1111 regardless of switches; then rst_n pulsed low mid-debounce -> all outputs 0 immediately and the subsequent debounce takes the full 4 counts.
REQ-034 Scenario: sweep switches through all values 0..15 with each held 10 cycles, mode=00 -> after each step leds equal the value, with latency 7.
